// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 5-stage LA32R pipeline.
//
// Latches {pc, inst} from fetch and decodes it. Holds the 32x32 register file,
// written by WB and read write-first. Checks RAW hazards against EX/MEM,
// resolves branches and hands the decoded bundle to EX.
//
// Optional feature: define ID_BYPASS_EN to forward EX/MEM results into the
// source operands. In that build only an EX load match stalls.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   IF_to_ID_valid/bus {pc, inst} from fetch
//   ID_allow_in        ID can take a bundle this cycle
//   ID_to_IF_bus       {br_taken, br_target}
//   EX_allow_in        EX can take a bundle
//   ID_to_EX_valid/bus {pc, alu_op, src1, src2, rkd_value, dest, gr_we, mem_we, res_from_mem}
//   WB_to_ID_bus       {we, waddr, wdata}
//   EX_fwd_bus         {we_valid, dest, is_load, result}
//   MEM_fwd_bus        {we_valid, dest, result}
module id_stage #(
    parameter int unsigned ALU_OP_W = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  IF_to_ID_valid,
    input  logic [63:0]           IF_to_ID_bus,
    output logic                  ID_allow_in,
    output logic [32:0]           ID_to_IF_bus,
    input  logic                  EX_allow_in,
    output logic                  ID_to_EX_valid,
    output logic [ALU_OP_W+135:0] ID_to_EX_bus,
    input  logic [37:0]           WB_to_ID_bus,
    input  logic [38:0]           EX_fwd_bus,
    input  logic [37:0]           MEM_fwd_bus
);

    logic        id_valid;
    logic        id_ready_go;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [31:0] inst;

    // Pipeline register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_valid <= 1'b0;
            pc       <= 32'h0;
            inst     <= 32'h0;
        end else begin
            if (ID_allow_in) begin
                id_valid <= IF_to_ID_valid & ~br_taken;
            end
            if (IF_to_ID_valid && ID_allow_in) begin
                pc   <= IF_to_ID_bus[63:32];
                inst <= IF_to_ID_bus[31:0];
            end
        end
    end

    assign ID_allow_in    = ~id_valid | (id_ready_go & EX_allow_in);
    assign ID_to_EX_valid = id_valid & id_ready_go;

    // Decode
    logic [16:0] op17;
    logic [9:0]  op10;
    logic [6:0]  op7;
    logic [5:0]  op6;
    assign op17 = inst[31:15];
    assign op10 = inst[31:22];
    assign op7  = inst[31:25];
    assign op6  = inst[31:26];

    logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor;
    logic i_slli, i_srli, i_srai, i_addi, i_lu12i, i_ld, i_st;
    logic i_jirl, i_b, i_bl, i_beq, i_bne;
    assign i_add   = op17 == 17'h00020;
    assign i_sub   = op17 == 17'h00022;
    assign i_slt   = op17 == 17'h00024;
    assign i_sltu  = op17 == 17'h00025;
    assign i_nor   = op17 == 17'h00028;
    assign i_and   = op17 == 17'h00029;
    assign i_or    = op17 == 17'h0002a;
    assign i_xor   = op17 == 17'h0002b;
    assign i_slli  = op17 == 17'h00081;
    assign i_srli  = op17 == 17'h00089;
    assign i_srai  = op17 == 17'h00091;
    assign i_addi  = op10 == 10'h00a;
    assign i_ld    = op10 == 10'h0a2;
    assign i_st    = op10 == 10'h0a6;
    assign i_lu12i = op7 == 7'h0a;
    assign i_jirl  = op6 == 6'h13;
    assign i_b     = op6 == 6'h14;
    assign i_bl    = op6 == 6'h15;
    assign i_beq   = op6 == 6'h16;
    assign i_bne   = op6 == 6'h17;

    logic is_3r, is_shift, is_imm12, is_itype, link, src2_is_rd, use_rj, use_r2;
    assign is_3r      = i_add | i_sub | i_slt | i_sltu | i_nor | i_and | i_or | i_xor;
    assign is_shift   = i_slli | i_srli | i_srai;
    assign is_imm12   = i_addi | i_ld | i_st;
    assign is_itype   = is_imm12 | is_shift | i_lu12i;
    assign link       = i_bl | i_jirl;
    assign src2_is_rd = i_beq | i_bne | i_st;
    assign use_rj     = is_3r | is_shift | is_imm12 | i_jirl | i_beq | i_bne;
    assign use_r2     = is_3r | i_beq | i_bne | i_st;

    logic [ALU_OP_W-1:0] alu_op;
    assign alu_op = {i_lu12i, i_srai, i_srli, i_slli, i_xor, i_or, i_nor, i_and,
                     i_sltu, i_slt, i_sub, i_add | is_imm12 | link};

    logic [4:0] rj, r2, rd, dest;
    assign rj   = inst[9:5];
    assign rd   = inst[4:0];
    assign r2   = src2_is_rd ? rd : inst[14:10];
    assign dest = i_bl ? 5'd1 : rd;

    logic [31:0] imm, offs16, offs26;
    assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    always_comb begin
        imm = 32'h0;
        if (is_imm12) begin
            imm = {{20{inst[21]}}, inst[21:10]};
        end else if (is_shift) begin
            imm = {27'h0, inst[14:10]};
        end else if (i_lu12i) begin
            imm = {inst[24:5], 12'h0};
        end
    end

    // Register file; r0 is never written and always reads 0
    logic [31:0] rf [32];
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    assign {wb_we, wb_waddr, wb_wdata} = WB_to_ID_bus;

    always_ff @(posedge clk) begin
        if (wb_we && wb_waddr != 5'd0) begin
            rf[wb_waddr] <= wb_wdata;
        end
    end

    // Write-first read, so WB never has to stall ID
    logic [31:0] rf_rj, rf_r2;
    assign rf_rj = (rj == 5'd0) ? 32'h0 :
                   (wb_we && wb_waddr == rj) ? wb_wdata : rf[rj];
    assign rf_r2 = (r2 == 5'd0) ? 32'h0 :
                   (wb_we && wb_waddr == r2) ? wb_wdata : rf[r2];

    // Hazard detection against EX/MEM destinations
    logic       ex_we, ex_is_load, mem_we;
    logic [4:0] ex_dest, mem_dest;
    logic       ex_hit_rj, ex_hit_r2, mem_hit_rj, mem_hit_r2;
    assign ex_we      = EX_fwd_bus[38];
    assign ex_dest    = EX_fwd_bus[37:33];
    assign ex_is_load = EX_fwd_bus[32];
    assign mem_we     = MEM_fwd_bus[37];
    assign mem_dest   = MEM_fwd_bus[36:32];
    assign ex_hit_rj  = use_rj & ex_we & (ex_dest == rj) & (rj != 5'd0);
    assign ex_hit_r2  = use_r2 & ex_we & (ex_dest == r2) & (r2 != 5'd0);
    assign mem_hit_rj = use_rj & mem_we & (mem_dest == rj) & (rj != 5'd0);
    assign mem_hit_r2 = use_r2 & mem_we & (mem_dest == r2) & (r2 != 5'd0);

    logic [31:0] rj_val, r2_val;
`ifdef ID_BYPASS_EN
    // EX is younger than MEM, so its result wins
    assign rj_val = ex_hit_rj ? EX_fwd_bus[31:0] : mem_hit_rj ? MEM_fwd_bus[31:0] : rf_rj;
    assign r2_val = ex_hit_r2 ? EX_fwd_bus[31:0] : mem_hit_r2 ? MEM_fwd_bus[31:0] : rf_r2;
    assign id_ready_go = ~(ex_is_load & (ex_hit_rj | ex_hit_r2));
`else
    logic unused_fwd;
    assign unused_fwd  = ^{ex_is_load, EX_fwd_bus[31:0], MEM_fwd_bus[31:0]};
    assign rj_val      = rf_rj;
    assign r2_val      = rf_r2;
    assign id_ready_go = ~(ex_hit_rj | ex_hit_r2 | mem_hit_rj | mem_hit_r2);
`endif

    // Operands
    logic [31:0] src1, src2;
    assign src1 = link ? pc : rj_val;
    assign src2 = link ? 32'd4 : is_itype ? imm : r2_val;

    logic gr_we;
    assign gr_we = is_3r | is_shift | i_addi | i_ld | i_lu12i | i_jirl | i_bl;

    assign ID_to_EX_bus = {pc, alu_op, src1, src2, r2_val, dest, gr_we, i_st, i_ld};

    // Branch resolution; only fires on the cycle the bundle moves to EX
    logic taken;
    assign taken     = i_b | i_bl | i_jirl | (i_beq & (rj_val == r2_val)) |
                       (i_bne & (rj_val != r2_val));
    assign br_taken  = id_valid & id_ready_go & EX_allow_in & taken;
    assign br_target = !br_taken ? 32'h0 :
                       i_jirl ? rj_val + offs16 :
                       pc + ((i_b | i_bl) ? offs26 : offs16);

    assign ID_to_IF_bus = {br_taken, br_target};

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic         clk;
    logic         resetn;
    logic         IF_to_ID_valid;
    logic [63:0]  IF_to_ID_bus;
    logic         ID_allow_in;
    logic [32:0]  ID_to_IF_bus;
    logic         EX_allow_in;
    logic         ID_to_EX_valid;
    logic [147:0] ID_to_EX_bus;
    logic [37:0]  WB_to_ID_bus;
    logic [38:0]  EX_fwd_bus;
    logic [37:0]  MEM_fwd_bus;

    id_stage #(.ALU_OP_W(12)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .IF_to_ID_valid (IF_to_ID_valid),
        .IF_to_ID_bus   (IF_to_ID_bus),
        .ID_allow_in    (ID_allow_in),
        .ID_to_IF_bus   (ID_to_IF_bus),
        .EX_allow_in    (EX_allow_in),
        .ID_to_EX_valid (ID_to_EX_valid),
        .ID_to_EX_bus   (ID_to_EX_bus),
        .WB_to_ID_bus   (WB_to_ID_bus),
        .EX_fwd_bus     (EX_fwd_bus),
        .MEM_fwd_bus    (MEM_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [147:0] bus;
        logic [32:0]  br;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t cur;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [11:0] alu,
                                input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] rkd, input logic [4:0] dest,
                                input logic gwe, input logic mwe, input logic rfm,
                                input logic brt, input logic [31:0] tgt);
        exp_t e;
        e.bus = {pc, alu, s1, s2, rkd, dest, gwe, mwe, rfm};
        e.br  = {brt, tgt};
        return e;
    endfunction

    task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every transfer to EX must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && ID_to_EX_valid && EX_allow_in) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_xfer: got bus %h expected no transfer", ID_to_EX_bus);
            end else begin
                mon_e = sb.pop_front();
                chk("xfer_bus", ID_to_EX_bus, mon_e.bus);
                chk("xfer_br", 148'(ID_to_IF_bus), 148'(mon_e.br));
            end
        end
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WB_to_ID_bus = {1'b1, a, d};
        @(posedge clk);
        #1;
        WB_to_ID_bus = '0;
    endtask

    // Present a bundle and return #1 after the edge that accepted it
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e,
                         input bit push);
        int n;
        if (push) sb.push_back(e);
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {pc, inst};
        n = 0;
        @(negedge clk);
        while (!ID_allow_in && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept_timeout", 148'(ID_allow_in), 148'(1));
        @(posedge clk);
        #1;
        IF_to_ID_valid = 1'b0;
        IF_to_ID_bus   = '0;
    endtask

    task automatic run(input logic [31:0] pc, input logic [31:0] inst, input exp_t e,
                       input bit is_br);
        issue(pc, inst, e, 1'b1);
        // Keep fetch idle while a taken branch leaves, so nothing is dropped
        if (is_br) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        resetn         = 1'b0;
        EX_allow_in    = 1'b1;
        WB_to_ID_bus   = '0;
        EX_fwd_bus     = '0;
        MEM_fwd_bus    = '0;
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'h1C000000, 32'h001000E5};

        // Reset, with fetch trying to push a bundle in
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 148'(ID_to_EX_valid), 148'(0));
        chk("rst_if_bus", 148'(ID_to_IF_bus), 148'(0));
        chk("rst_allow_in", 148'(ID_allow_in), 148'(1));
        chk("rst_ex_bus", ID_to_EX_bus, 148'(0));
        IF_to_ID_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i < 32; i++) wb_write(5'(i), 32'h10000000 + 32'(i));

        // Write-first: r7 written by WB in the same cycle add.w r5,r7,r0 reads it
        issue(32'h1C000000, 32'h001000E5,
              mk(32'h1C000000, 12'h001, 32'hDEADBEEF, 0, 0, 5'd5, 1, 0, 0, 0, 0), 1'b1);
        WB_to_ID_bus = {1'b1, 5'd7, 32'hDEADBEEF};
        @(posedge clk);
        #1;
        WB_to_ID_bus = '0;

        // WB write to r0 alongside add.w r8,r0,r0
        issue(32'h1C000004, 32'h00100008,
              mk(32'h1C000004, 12'h001, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0), 1'b1);
        WB_to_ID_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
        @(posedge clk);
        #1;
        WB_to_ID_bus = '0;

        // Taken beq r4,r4,+16; the fetch bundle arriving with it is dropped
        issue(32'h1C000010, 32'h58001084,
              mk(32'h1C000010, 12'h000, 32'h10000004, 32'h10000004, 32'h10000004, 5'd4,
                 0, 0, 0, 1, 32'h1C000020), 1'b1);
        IF_to_ID_valid = 1'b1;
        IF_to_ID_bus   = {32'h1C000014, 32'h00101085};
        @(posedge clk);
        #1;
        IF_to_ID_valid = 1'b0;
        IF_to_ID_bus   = '0;
        @(negedge clk);
        chk("drop_valid", 148'(ID_to_EX_valid), 148'(0));
        chk("drop_allow_in", 148'(ID_allow_in), 148'(1));

        // Back-pressure on a taken bne r4,r6,-8
        @(posedge clk);
        #1;
        EX_allow_in = 1'b0;
        cur = mk(32'h1C000040, 12'h000, 32'h10000004, 32'h10000006, 32'h10000006, 5'd6,
                 0, 0, 0, 1, 32'h1C000038);
        issue(32'h1C000040, 32'h5FFFF886, cur, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid", 148'(ID_to_EX_valid), 148'(1));
            chk("bp_allow_in", 148'(ID_allow_in), 148'(0));
            chk("bp_br", 148'(ID_to_IF_bus), 148'(0));
            chk("bp_bus", ID_to_EX_bus, cur.bus);
        end
        @(posedge clk);
        #1;
        EX_allow_in = 1'b1;
        @(posedge clk);
        #1;

`ifdef ID_BYPASS_EN
        // EX beats MEM, no stall
        EX_fwd_bus  = {1'b1, 5'd4, 1'b0, 32'h99};
        MEM_fwd_bus = {1'b1, 5'd4, 32'h55};
        issue(32'h1C000080, 32'h00101085,
              mk(32'h1C000080, 12'h001, 32'h99, 32'h99, 32'h99, 5'd5, 1, 0, 0, 0, 0), 1'b1);
        @(negedge clk);
        chk("byp_no_stall", 148'(ID_to_EX_valid), 148'(1));
        @(posedge clk);
        #1;
        // Load-use: one stall cycle, then the MEM value
        EX_fwd_bus  = {1'b1, 5'd4, 1'b1, 32'h77};
        MEM_fwd_bus = '0;
        issue(32'h1C000084, 32'h00101085,
              mk(32'h1C000084, 12'h001, 32'h99, 32'h99, 32'h99, 5'd5, 1, 0, 0, 0, 0), 1'b1);
        @(negedge clk);
        chk("load_use_stall", 148'(ID_to_EX_valid), 148'(0));
        @(posedge clk);
        #1;
        EX_fwd_bus  = '0;
        MEM_fwd_bus = {1'b1, 5'd4, 32'h99};
        @(negedge clk);
        chk("load_use_resume", 148'(ID_to_EX_valid), 148'(1));
        @(posedge clk);
        #1;
        MEM_fwd_bus = '0;
`else
        // RAW on r4: stall while EX, then MEM, hold r4 as destination
        EX_fwd_bus = {1'b1, 5'd4, 1'b0, 32'h0};
        issue(32'h1C000080, 32'h00101085,
              mk(32'h1C000080, 12'h001, 32'h10000004, 32'h10000004, 32'h10000004, 5'd5,
                 1, 0, 0, 0, 0), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("raw_ex_stall", 148'(ID_to_EX_valid), 148'(0));
        end
        @(posedge clk);
        #1;
        EX_fwd_bus  = '0;
        MEM_fwd_bus = {1'b1, 5'd4, 32'h0};
        repeat (2) begin
            @(negedge clk);
            chk("raw_mem_stall", 148'(ID_to_EX_valid), 148'(0));
        end
        @(posedge clk);
        #1;
        MEM_fwd_bus = '0;
        @(negedge clk);
        chk("raw_clear", 148'(ID_to_EX_valid), 148'(1));
        @(posedge clk);
        #1;
`endif

        // r0 sources never stall, even against a load writing r0
        EX_fwd_bus  = {1'b1, 5'd0, 1'b1, 32'h0};
        MEM_fwd_bus = {1'b1, 5'd0, 32'h0};
        issue(32'h1C000090, 32'h0010000A,
              mk(32'h1C000090, 12'h001, 0, 0, 0, 5'd10, 1, 0, 0, 0, 0), 1'b1);
        @(negedge clk);
        chk("r0_no_stall", 148'(ID_to_EX_valid), 148'(1));
        @(posedge clk);
        #1;
        EX_fwd_bus  = '0;
        MEM_fwd_bus = '0;

        // Directed decode vectors, back to back
        run(32'h1C0000A0, 32'h02BE108B, mk(32'h1C0000A0, 12'h001, 32'h10000004, 32'hFFFFFF84,
            32'h10000004, 5'd11, 1, 0, 0, 0, 0), 1'b0);                    // addi.w r11,r4,-124
        run(32'h1C0000A4, 32'h288018CC, mk(32'h1C0000A4, 12'h001, 32'h10000006, 32'h6,
            32'h10000006, 5'd12, 1, 0, 1, 0, 0), 1'b0);                    // ld.w r12,r6,6
        run(32'h1C0000A8, 32'h298010C4, mk(32'h1C0000A8, 12'h001, 32'h10000006, 32'h4,
            32'h10000004, 5'd4, 0, 1, 0, 0, 0), 1'b0);                     // st.w r4,r6,4
        run(32'h1C0000AC, 32'h0048988D, mk(32'h1C0000AC, 12'h400, 32'h10000004, 32'h6,
            32'h10000006, 5'd13, 1, 0, 0, 0, 0), 1'b0);                    // srai.w r13,r4,6
        run(32'h1C0000B0, 32'h142468AE, mk(32'h1C0000B0, 12'h800, 32'h10000005, 32'h12345000,
            32'h1000001A, 5'd14, 1, 0, 0, 0, 0), 1'b0);                    // lu12i.w r14,0x12345
        run(32'h1C0000B4, 32'h001290D0, mk(32'h1C0000B4, 12'h008, 32'h10000006, 32'h10000004,
            32'h10000004, 5'd16, 1, 0, 0, 0, 0), 1'b0);                    // sltu r16,r6,r4
        run(32'h1C0000B8, 32'hFFFFFFFF, mk(32'h1C0000B8, 12'h000, 32'h1000001F, 32'h1000001F,
            32'h1000001F, 5'd31, 0, 0, 0, 0, 0), 1'b0);                    // undefined -> NOP
        run(32'h1C000100, 32'h57FFFFFF, mk(32'h1C000100, 12'h001, 32'h1C000100, 32'h4,
            32'h1000001F, 5'd1, 1, 0, 0, 1, 32'h1C0000FC), 1'b1);          // bl -4
        run(32'h1C000200, 32'h4C0010CF, mk(32'h1C000200, 12'h001, 32'h1C000200, 32'h4,
            32'h10000004, 5'd15, 1, 0, 0, 1, 32'h10000016), 1'b1);         // jirl r15,r6,16

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 148'(sb.size()), 148'(0));

        // Reset while a bundle is stalled in ID
        EX_allow_in = 1'b0;
        issue(32'h1C000300, 32'h00101085, cur, 1'b0);
        @(negedge clk);
        chk("midrst_held", 148'(ID_to_EX_valid), 148'(1));
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", 148'(ID_to_EX_valid), 148'(0));
        chk("midrst_allow_in", 148'(ID_allow_in), 148'(1));
        chk("midrst_if_bus", 148'(ID_to_IF_bus), 148'(0));
        chk("midrst_ex_bus", ID_to_EX_bus, 148'(0));
        resetn = 1'b1;
        @(posedge clk);
        #1;
        EX_allow_in = 1'b1;
        @(negedge clk);
        chk("midrst_discard", 148'(ID_to_EX_valid), 148'(0));
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage LA32R pipeline. Sits directly downstream of the fetch stage and upstream of EX.
- Latches {pc, inst} from fetch and decodes it. Reads the internal 32x32 register file, which is written by WB.
- Detects RAW hazards against EX/MEM and resolves branches in ID, returning {br_taken, br_target} to fetch.
- Emits the decoded bundle to EX under valid/allow_in handshakes.

Parameters:
- ALU_OP_W, 12, width of the one-hot ALU op field. Bit order [11:0] = lui, sra, srl, sll, xor, or, nor, and, sltu, slt, sub, add.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low. Clock is clk.
- IF_to_ID_valid  in  1  fetch bundle valid
- IF_to_ID_bus  in  64  {pc[31:0], inst[31:0]}
- ID_allow_in  out  1  ID can accept a bundle this cycle
- ID_to_IF_bus  out  33  {br_taken, br_target[31:0]}
- EX_allow_in  in  1  EX can accept
- ID_to_EX_valid  out  1  decoded bundle valid
- ID_to_EX_bus  out  148  MSB->LSB: {pc[31:0], alu_op[11:0], src1[31:0], src2[31:0], rkd_value[31:0], dest[4:0], gr_we, mem_we, res_from_mem}
- WB_to_ID_bus  in  38  {we, waddr[4:0], wdata[31:0]}; we already qualified by WB valid
- EX_fwd_bus  in  39  {we_valid, dest[4:0], is_load, result[31:0]}
- MEM_fwd_bus  in  38  {we_valid, dest[4:0], result[31:0]}

Behaviour:
- ID_valid register: 0 on reset. When ID_allow_in=1: ID_valid <= IF_to_ID_valid & ~br_taken. Bundle register loads on IF_to_ID_valid & ID_allow_in.
- ID_allow_in = ~ID_valid | (ID_ready_go & EX_allow_in).
- ID_to_EX_valid = ID_valid & ID_ready_go.
- Decoded outputs are combinational from the bundle register. They are held stable while EX_allow_in=0.
- Decoded set:
  - 3R: add.w, sub.w, slt, sltu, nor, and, or, xor
  - Shift-immediate: slli.w, srli.w, srai.w
  - addi.w, lu12i.w, ld.w, st.w
  - Control: jirl, b, bl, beq, bne
  - Any other encoding is a NOP: gr_we=0, mem_we=0, no branch, no hazard check.
- Immediates:
  - si12: sign-extended (addi, ld, st)
  - ui5: zero-extended (shifts)
  - lu12i: {si20, 12'b0}
  - offs16: sign-extended, shifted left 2
  - offs26 = {inst[9:0], inst[25:10]}: sign-extended, shifted left 2
- Operand sources:
  - rj = inst[9:5]
  - Second register = rk (inst[14:10]) for 3R; rd for beq, bne, st.w
  - rkd_value = second register value (store data)
  - src1 = pc for bl/jirl, else rj value
  - src2 = 4 for bl/jirl, immediate for I-type, else second register value
- dest: 1 for bl, rd otherwise. gr_we = 0 for st, b, beq, bne.
- Branch resolution:
  - Targets: beq/bne/b/bl = pc + offs; jirl = rj_value + offs16<<2.
  - br_taken = ID_valid & ID_ready_go & EX_allow_in & taken. It asserts only on the transfer cycle, so there is no branch while stalled.
  - br_target is 0 when br_taken=0.
- Register file:
  - WB write on we with waddr!=0. r0 always reads 0.
  - Same-cycle write/read of the same register returns wdata (write-first).
- Hazards (without ID_BYPASS_EN):
  - ID_ready_go=0 if any used nonzero source equals the dest of EX_fwd_bus or MEM_fwd_bus with we_valid=1.
  - WB needs no stall because the register file is write-first.
- Reset mid-operation: ID_valid=0 and the bundle is discarded. All outputs read as 0 except ID_allow_in=1.

Optional Feature:
- Macro ID_BYPASS_EN.
- Defined:
  - Source values are muxed with priority EX result > MEM result > register file, on dest match with we_valid.
  - Stall only when the EX match has is_load=1 (load-use, one cycle minimum).
- Undefined:
  - Result fields are ignored; stall on any EX/MEM match as above.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> ID_to_EX_valid=0, ID_to_IF_bus=0, ID_allow_in=1. Release -> the first fetch bundle is accepted next edge.
- Write-first: WB_to_ID_bus={1,7,0xDEADBEEF} same cycle as add.w r5,r7,r0 in ID -> src1=0xDEADBEEF, src2=0, dest=5, alu_op=add. WB write to r0 leaves r0 reading 0.
- Taken branch: beq r4,r4 at pc=0x1C000010 with offs16=4, EX_allow_in=1 -> br_taken=1, br_target=0x1C000020 for one cycle. The fetch bundle arriving that edge is dropped (ID_valid=0 next cycle).
- Back-pressure: ID_valid=1, EX_allow_in=0 for 4 cycles -> ID_allow_in=0, ID_to_EX_bus constant, br_taken=0.
- RAW, no bypass: EX_fwd_bus={1,4,0,x} while ID holds add.w r5,r4,r4 -> ID_to_EX_valid=0 until the match clears. r0 sources never stall.
- Bypass (ID_BYPASS_EN): MEM_fwd={1,4,0x55}, EX_fwd={1,4,0,0x99} -> src1=0x99, no stall. With EX is_load=1 -> one-cycle stall, then MEM value 0x99 is used.
